axil_cmd_sequencer: RTL

Command sequencer that sits directly upstream of the AXI-lite master's user port and feeds it.
- Accepts read/write commands from a producer over a valid/ready interface and buffers them in a FIFO.
- Issues commands one at a time to the master, using its user_start / user_free handshake.
- Returns one response per command (read data, AXI status, timeout flag) over a second valid/ready interface.
- Lets software or a traffic engine stream transactions without hand-timing user_start against user_free.

---
 rtl/axil_seq_pkg.sv | 37 +++
 rtl/axil_cmd_sequencer_if.sv | 49 ++++
 rtl/axil_seq_fifo.sv | 70 +++++++
 rtl/axil_cmd_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/axil_seq_pkg.sv
// Shared types for the AXI-lite command sequencer: bus widths, command and
// response payloads, FSM states and AXI response codes.
package axil_seq_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef struct packed {
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        status;
    logic              timeout;
  } rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACC,
    ST_WAIT_DONE,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_sequencer_if.sv
// Command, response and master-user-port signals of the sequencer.
// master = the sequencer itself, slave = producer/consumer/AXI-lite master side.
interface axil_cmd_sequencer_if;
  import axil_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_w_r;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_w_r;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;
  logic              rsp_timeout;

  logic              user_start;
  logic              user_w_r;
  logic [ADDR_W-1:0] user_addr_in;
  logic [DATA_W-1:0] user_data_in;
  logic [STRB_W-1:0] user_data_strb;
  logic              user_free;
  logic [1:0]        user_status;
  logic [DATA_W-1:0] user_data_out;
  logic              user_data_out_valid;

  modport master (
    input  cmd_valid, cmd_w_r, cmd_addr, cmd_data, cmd_strb,
    input  rsp_ready,
    input  user_free, user_status, user_data_out, user_data_out_valid,
    output cmd_ready,
    output rsp_valid, rsp_w_r, rsp_addr, rsp_data, rsp_status, rsp_timeout,
    output user_start, user_w_r, user_addr_in, user_data_in, user_data_strb
  );

  modport slave (
    output cmd_valid, cmd_w_r, cmd_addr, cmd_data, cmd_strb,
    output rsp_ready,
    output user_free, user_status, user_data_out, user_data_out_valid,
    input  cmd_ready,
    input  rsp_valid, rsp_w_r, rsp_addr, rsp_data, rsp_status, rsp_timeout,
    input  user_start, user_w_r, user_addr_in, user_data_in, user_data_strb
  );

endinterface

// File: rtl/axil_seq_fifo.sv
// Synchronous command FIFO with registered ready/empty flags and exact level.
// DEPTH must be a power of two so the pointers wrap naturally.
module axil_seq_fifo
  import axil_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  cmd_t                   i_data,
  input  logic                   i_pop,
  output logic                   o_ready,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level,
  output cmd_t                   o_head_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             r_ready;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && r_ready;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Flags are registered from the next level; ready stays low during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(DEPTH));
      r_empty <= (w_level_nxt == LVL_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_ready  = r_ready;
  assign o_empty  = r_empty;
  assign o_level  = r_level;
  assign o_head_c = r_mem[r_rd_ptr];

endmodule

// File: rtl/axil_cmd_sequencer.sv
// Buffers read/write commands, issues them one at a time to the AXI-lite
// master via user_start/user_free, and returns one response per command.
module axil_cmd_sequencer
  import axil_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  axil_cmd_sequencer_if.master        bus,
  output logic [15:0]                 err_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  cmd_t             w_cmd_in;
  cmd_t             w_head_c;
  logic             w_fifo_ready;
  logic             w_fifo_empty;
  logic [LVL_W-1:0] w_level;

  state_e           r_state;
  state_e           w_state_nxt;
  cmd_t             r_hold;
  rsp_t             r_rsp;
  rsp_t             w_rsp_nxt;
  logic             r_rsp_valid;
  logic             r_user_start;
  logic             r_got_data;
  logic [DATA_W-1:0] r_rd_data;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [15:0]      r_err_cnt;

  logic             w_pop;
  logic             w_rsp_ld;
  logic             w_rsp_hs;
  logic             w_cap;
  logic             w_err;

  assign w_cmd_in = cmd_t'{w_r:  bus.cmd_w_r,
                           addr: bus.cmd_addr,
                           data: bus.cmd_data,
                           strb: bus.cmd_strb};

  axil_seq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .i_push   (bus.cmd_valid),
    .i_data   (w_cmd_in),
    .i_pop    (w_pop),
    .o_ready  (w_fifo_ready),
    .o_empty  (w_fifo_empty),
    .o_level  (w_level),
    .o_head_c (w_head_c)
  );

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, FIFO pop, response load and capture strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rsp_ld    = 1'b0;
    w_rsp_hs    = 1'b0;
    w_cap       = 1'b0;
    w_rsp_nxt   = r_rsp;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && bus.user_free) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT_ACC;
      ST_WAIT_ACC: begin
        if (!bus.user_free) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = ST_RESP;
          w_rsp_ld    = 1'b1;
          w_rsp_nxt   = rsp_t'{w_r: r_hold.w_r, addr: r_hold.addr,
                               data: DATA_W'(0), status: RESP_OKAY,
                               timeout: 1'b1};
        end
      end
      ST_WAIT_DONE: begin
        w_cap = bus.user_data_out_valid && r_hold.w_r;
        if (bus.user_free) begin
          w_state_nxt = ST_RESP;
          w_rsp_ld    = 1'b1;
          w_rsp_nxt   = rsp_t'{w_r: r_hold.w_r, addr: r_hold.addr,
                               data: w_cap ? bus.user_data_out : r_rd_data,
                               status: bus.user_status, timeout: 1'b0};
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_hs    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A read that never saw its data strobe counts as an error too.
  assign w_err = (r_rsp.status != RESP_OKAY) || r_rsp.timeout ||
                 (r_rsp.w_r && !r_got_data);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_hold       <= '0;
      r_rsp        <= '0;
      r_rsp_valid  <= 1'b0;
      r_user_start <= 1'b0;
      r_got_data   <= 1'b0;
      r_rd_data    <= '0;
      r_tmo_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_user_start <= (w_state_nxt == ST_ISSUE);
      r_rsp_valid  <= (w_state_nxt == ST_RESP);
      if (w_pop) r_hold <= w_head_c;
      if (r_state == ST_ISSUE) begin
        r_tmo_cnt  <= '0;
        r_got_data <= 1'b0;
        r_rd_data  <= '0;
      end else begin
        if (r_state == ST_WAIT_ACC) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        if (w_cap) begin
          r_got_data <= 1'b1;
          r_rd_data  <= bus.user_data_out;
        end
      end
      if (w_rsp_ld) r_rsp <= w_rsp_nxt;
      if (w_rsp_hs && w_err && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.cmd_ready      = w_fifo_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_w_r        = r_rsp.w_r;
  assign bus.rsp_addr       = r_rsp.addr;
  assign bus.rsp_data       = r_rsp.data;
  assign bus.rsp_status     = r_rsp.status;
  assign bus.rsp_timeout    = r_rsp.timeout;
  assign bus.user_start     = r_user_start;
  assign bus.user_w_r       = r_hold.w_r;
  assign bus.user_addr_in   = r_hold.addr;
  assign bus.user_data_in   = r_hold.data;
  assign bus.user_data_strb = r_hold.strb;
  assign err_count          = r_err_cnt;
  assign fifo_level         = w_level;

endmodule
